// File: rtl/ed25519_sign_pkg.sv
// Shared definitions for the Ed25519 signing hash loader: loader states,
// digest source tags and digest width.
package ed25519_sign_pkg;

  localparam int DIGEST_W = 512;

  localparam logic [1:0] TAG_KEY = 2'd0;
  localparam logic [1:0] TAG_RAM = 2'd1;
  localparam logic [1:0] TAG_SM  = 2'd2;

  typedef enum logic [2:0] {
    LD_KEY,
    LD_RAM,
    LD_SM,
    WAIT_RDY,
    START,
    RUN,
    FIN
  } ld_state_e;

endpackage

// File: rtl/ed25519_digest_shreg.sv
// 512-bit digest register filled by shifting in WORD_W-bit words at the LSBs,
// so the first word of a digest ends up at the MSBs.
module ed25519_digest_shreg
  import ed25519_sign_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_en,
  input  logic [WORD_W-1:0]   word_in,
  output logic [DIGEST_W-1:0] digest
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       digest <= '0;
    else if (load_en) digest <= {digest[DIGEST_W-WORD_W-1:0], word_in};
  end

endmodule

// File: rtl/ed25519_sign_hash_loader.sv
// Collects key/ram/sm SHA-512 digests from a word stream and launches the S-core.
// Optional ITAG source checking with sticky OERR: ED25519_LOADER_TAG_CHECK_EN.
module ed25519_sign_hash_loader
  import ed25519_sign_pkg::*;
#(
  parameter int WORD_W = 64
) (
  input  logic                ICLK,
  input  logic                IRST_N,
  input  logic                IWORD_VALID,
  output logic                OWORD_READY,
  input  logic [WORD_W-1:0]   IWORD,
  input  logic [1:0]          ITAG,
  input  logic                IKEY_KEEP,
  output logic [DIGEST_W-1:0] OHASHD_KEY,
  output logic [DIGEST_W-1:0] OHASHD_RAM,
  output logic [DIGEST_W-1:0] OHASHD_SM,
  output logic                OCORE_ENA,
  input  logic                ICORE_READY,
  input  logic                ICORE_DONE,
  output logic                OBUSY,
  output logic                ODONE,
  output logic                OERR
);

  localparam int              NWORDS   = DIGEST_W / WORD_W;
  localparam int              CNT_W    = $clog2(NWORDS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NWORDS - 1);

  ld_state_e        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             key_valid, key_valid_nxt;
  logic             load_phase, xfer, skip_key, tag_err;
  logic             ld_key, ld_ram, ld_sm;

  assign load_phase  = (state == LD_KEY) || (state == LD_RAM) || (state == LD_SM);
  // Gated by reset so every output reads 0 while IRST_N is low.
  assign OWORD_READY = load_phase & IRST_N;
  assign xfer        = IWORD_VALID & load_phase;
  assign skip_key    = (state == LD_KEY) && (cnt == '0) && IKEY_KEEP && key_valid;

`ifdef ED25519_LOADER_TAG_CHECK_EN
  logic [1:0] exp_tag;
  logic       err_q;

  assign exp_tag = (state == LD_SM)                   ? TAG_SM  :
                   ((state == LD_RAM) || skip_key)    ? TAG_RAM : TAG_KEY;
  assign tag_err = xfer && (ITAG != exp_tag);

  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N)      err_q <= 1'b0;
    else if (tag_err) err_q <= 1'b1;
  end
  assign OERR = err_q;
`else
  logic unused_tag;
  assign unused_tag = ^ITAG;
  assign tag_err    = 1'b0;
  assign OERR       = 1'b0;
`endif

  always_ff @(posedge ICLK or negedge IRST_N) begin
    if (!IRST_N) begin
      state     <= LD_KEY;
      cnt       <= '0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      key_valid <= key_valid_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    key_valid_nxt = key_valid;
    ld_key        = 1'b0;
    ld_ram        = 1'b0;
    ld_sm         = 1'b0;
    if (tag_err) begin
      state_nxt     = LD_KEY;
      cnt_nxt       = '0;
      key_valid_nxt = 1'b0;
    end else begin
      unique case (state)
        LD_KEY: if (xfer) begin
          if (skip_key) begin
            // Reused key: this first word is already ram word 0.
            ld_ram    = 1'b1;
            cnt_nxt   = CNT_W'(1);
            state_nxt = LD_RAM;
          end else begin
            ld_key  = 1'b1;
            cnt_nxt = cnt + 1'b1;
            if (cnt == CNT_LAST) begin
              key_valid_nxt = 1'b1;
              state_nxt     = LD_RAM;
            end
          end
        end
        LD_RAM: if (xfer) begin
          ld_ram  = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = LD_SM;
        end
        LD_SM: if (xfer) begin
          ld_sm   = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CNT_LAST) state_nxt = ICORE_READY ? START : WAIT_RDY;
        end
        WAIT_RDY: if (ICORE_READY) state_nxt = START;
        START:    state_nxt = RUN;
        RUN:      if (ICORE_DONE) state_nxt = FIN;
        FIN:      state_nxt = LD_KEY;
        default:  state_nxt = LD_KEY;
      endcase
    end
  end

  assign OCORE_ENA = (state == START);
  assign ODONE     = (state == FIN);
  assign OBUSY     = (state != LD_KEY) || (cnt != '0);

  ed25519_digest_shreg #(.WORD_W(WORD_W)) u_key_reg (
    .clk(ICLK), .rst_n(IRST_N), .load_en(ld_key), .word_in(IWORD), .digest(OHASHD_KEY)
  );
  ed25519_digest_shreg #(.WORD_W(WORD_W)) u_ram_reg (
    .clk(ICLK), .rst_n(IRST_N), .load_en(ld_ram), .word_in(IWORD), .digest(OHASHD_RAM)
  );
  ed25519_digest_shreg #(.WORD_W(WORD_W)) u_sm_reg (
    .clk(ICLK), .rst_n(IRST_N), .load_en(ld_sm), .word_in(IWORD), .digest(OHASHD_SM)
  );

endmodule

// File: doc/ed25519_sign_hash_loader.md
Name: ed25519_sign_hash_loader

Overview:
- Upstream stage of the Ed25519 signing S-core.
- Collects three SHA-512 digests from the hash engine as a word stream: key digest, nonce (ram) digest and message-challenge (sm) digest.
- Assembles them into 512-bit registers and launches the S-core with a single-cycle enable pulse.
- Tracks S-core completion and reports done.

Parameters:
- WORD_W, 64, stream word width; legal values 32 or 64.
- NWORDS, 512/WORD_W, words per digest (derived; not overridable).

Ports:
- ICLK  in  1  clock
- IRST_N  in  1  async active-low reset
- IWORD_VALID  in  1  stream word valid
- OWORD_READY  out  1  loader accepts a word this cycle
- IWORD  in  WORD_W  digest word; first word = bits [511:512-WORD_W]
- ITAG  in  2  word source: 0 key, 1 ram, 2 sm
- IKEY_KEEP  in  1  sampled at first word of a job; 1 = reuse stored key digest, skip key load
- OHASHD_KEY  out  512  assembled key digest
- OHASHD_RAM  out  512  assembled ram digest
- OHASHD_SM  out  512  assembled sm digest
- OCORE_ENA  out  1  one-cycle start pulse to S-core
- ICORE_READY  in  1  S-core idle
- ICORE_DONE  in  1  S-core completion pulse
- OBUSY  out  1  job in progress
- ODONE  out  1  one-cycle job-complete pulse
- OERR  out  1  sticky tag error (feature only; tied 0 otherwise)

Behaviour:
- Clock and reset: one clock ICLK; reset IRST_N is asynchronous and active-low.
- Reset values: all outputs 0, all digest registers 0, state LD_KEY, word counter 0, key_valid flag 0.
- States: LD_KEY, LD_RAM, LD_SM, WAIT_RDY, START, RUN, FIN.
- OWORD_READY = 1 only in LD_KEY/LD_RAM/LD_SM; transfer = IWORD_VALID & OWORD_READY.
- Assembly: each transfer shifts the target register left by WORD_W and inserts IWORD at the LSBs. After NWORDS transfers, the first word sits at the MSBs.
- Word counter: log2(NWORDS) bits, increments per transfer. On the last word it wraps to 0 and the state advances.
- First transfer of a job (counter 0 in LD_KEY):
  - if IKEY_KEEP=1 and key_valid=1: the word is routed to RAM, and the state jumps to LD_RAM with counter=1.
  - if IKEY_KEEP=1 but key_valid=0: IKEY_KEEP is ignored and the key is loaded.
- OBUSY = 1 from the first accepted word until ODONE, inclusive.
- LD_KEY complete -> key_valid=1, go to LD_RAM. LD_RAM complete -> LD_SM. LD_SM complete -> WAIT_RDY.
- WAIT_RDY -> START when ICORE_READY=1.
  - Minimum latency: OCORE_ENA high in the cycle immediately after the last sm word is accepted if ICORE_READY was already 1.
- START: OCORE_ENA=1 for exactly one cycle, then RUN.
- RUN: wait for ICORE_DONE.
  - An ICORE_DONE seen in the START cycle is ignored.
  - An ICORE_DONE seen in the first RUN cycle is accepted.
- FIN: ODONE=1 for one cycle, then LD_KEY. key_valid is retained.
- Digest outputs are held stable from the START cycle until the next transfer, so the S-core may sample them at any time during RUN.
- Stray ICORE_DONE in any state other than RUN: ignored.
- Reset mid-job: all state is lost immediately, key_valid=0, OCORE_ENA is deasserted asynchronously.
- ITAG is ignored when the feature is off.

Optional Feature:
- Macro: ED25519_LOADER_TAG_CHECK_EN.
- Defined:
  - Each transfer compares ITAG with the expected source for the current state.
  - On mismatch the word is discarded, OERR is set (sticky) and the state goes to LD_KEY with counter 0; key_valid is cleared.
  - OERR clears only on reset.
  - A tag-1 first word with a valid IKEY_KEEP is legal.
- Undefined: OERR is tied to 0 and no comparison logic is generated.

Decomposition:
- Package ed25519_sign_pkg holds:
  - state encoding enum (7 states);
  - tag constants TAG_KEY=0, TAG_RAM=1, TAG_SM=2;
  - DIGEST_W=512.
- One natural sub-module: ed25519_digest_shreg, a parametric WORD_W shift-in 512-bit register with load-enable, instanced three times.

Test Plan:
- Full job, WORD_W=64, ICORE_READY=1: 24 back-to-back words (key words 0x1111..._0000+i, ram 0x2222..., sm 0x3333...) -> OHASHD_KEY[511:448]=0x1111..._0000, [63:0]=word 7. OCORE_ENA pulses one cycle after the 24th transfer. ICORE_DONE 10 cycles later -> ODONE one cycle after it; OBUSY then falls.
- Backpressure and bubbles: IWORD_VALID toggled randomly, ICORE_READY=0 for 50 cycles after load -> no OCORE_ENA until ICORE_READY rises, then exactly one pulse. Digests unchanged.
- Key reuse: second job with IKEY_KEEP=1 and 16 words -> OHASHD_KEY identical to job 1, launch after 16 words. Same stimulus after reset -> IKEY_KEEP ignored, 24 words required.
- Stray/edge ICORE_DONE: DONE pulsed during LD_SM and during START -> ignored. DONE in the first RUN cycle -> ODONE next cycle.
- Reset mid-RUN: assert IRST_N=0 -> all outputs 0 asynchronously. The next job with IKEY_KEEP=1 still loads 24 words.
- With ED25519_LOADER_TAG_CHECK_EN: ITAG=2 on ram word 3 -> OERR=1, no OCORE_ENA, state LD_KEY. A new correct 24-word job completes normally while OERR stays 1.
